// File: rtl/branch_resolve_ctrl_if.sv
// rtl/branch_resolve_ctrl_if.sv - branch issue and fetch redirect handshake bundle
interface branch_resolve_ctrl_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      Br_Ctrl;
    logic [XLEN-1:0] SrcA;
    logic [XLEN-1:0] SrcB;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic            pred_taken;
    logic            redirect_valid;
    logic            redirect_ready;
    logic [XLEN-1:0] redirect_pc;

    modport master (
        output in_valid, Br_Ctrl, SrcA, SrcB, pc, imm, pred_taken, redirect_ready,
        input  in_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  in_valid, Br_Ctrl, SrcA, SrcB, pc, imm, pred_taken, redirect_ready,
        output in_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// rtl/branch_resolve_ctrl.sv - branch resolve / mispredict redirect / flush sequencer
// Optional perf counters enabled by defining BRANCH_RESOLVE_PERF_EN.
module branch_resolve_ctrl #(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    branch_resolve_ctrl_if.slave bus,
    input  logic                 kill,
    output logic                 resolved_valid,
    output logic                 taken,
    output logic                 mispredict,
    output logic                 illegal,
    output logic                 flush,
    output logic [31:0]          br_count,
    output logic [31:0]          mispred_count
);
    localparam int CW = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EVAL     = 2'd1,
        REDIRECT = 2'd2,
        FLUSH    = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      ctrl_q;
    logic [XLEN-1:0] a_q, b_q, pc_q, imm_q;
    logic            pred_q;
    logic [CW-1:0]   fcnt_q, fcnt_d;
    logic            resolved_q, resolved_d;
    logic            taken_q, taken_d;
    logic            mis_q, mis_d;
    logic            ill_q, ill_d;
    logic            rv_q, rv_d;
    logic [XLEN-1:0] rpc_q, rpc_d;
    logic            flush_q, flush_d;

    logic            accept;
    logic            cond;
    logic            cond_ill;
    logic [XLEN-1:0] target;

    assign accept = (state_q == IDLE) && bus.in_valid;

    always_comb begin
        cond     = 1'b0;
        cond_ill = 1'b0;
        case (ctrl_q)
            3'b000:  cond = (a_q == b_q);
            3'b001:  cond = (a_q != b_q);
            3'b100:  cond = ($signed(a_q) <  $signed(b_q));
            3'b101:  cond = ($signed(a_q) >= $signed(b_q));
            3'b110:  cond = (a_q <  b_q);
            3'b111:  cond = (a_q >= b_q);
            default: cond_ill = 1'b1;
        endcase
        target = cond ? (pc_q + imm_q) : (pc_q + XLEN'(4));
    end

    always_comb begin
        state_d    = state_q;
        fcnt_d     = fcnt_q;
        resolved_d = 1'b0;
        taken_d    = 1'b0;
        mis_d      = 1'b0;
        ill_d      = 1'b0;
        rv_d       = rv_q;
        rpc_d      = rpc_q;
        flush_d    = flush_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = EVAL;
            end
            EVAL: begin
                if (kill) begin
                    state_d = IDLE;
                end else begin
                    resolved_d = 1'b1;
                    taken_d    = cond;
                    mis_d      = (cond != pred_q);
                    ill_d      = cond_ill;
                    rpc_d      = target;
                    if (cond != pred_q) begin
                        rv_d    = 1'b1;
                        state_d = REDIRECT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            REDIRECT: begin
                // kill takes priority over a simultaneous redirect accept
                if (kill) begin
                    rv_d    = 1'b0;
                    state_d = IDLE;
                end else if (bus.redirect_ready) begin
                    rv_d = 1'b0;
                    if (FLUSH_CYCLES > 0) begin
                        flush_d = 1'b1;
                        fcnt_d  = CW'(FLUSH_CYCLES);
                        state_d = FLUSH;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            FLUSH: begin
                if (fcnt_q <= CW'(1)) begin
                    flush_d = 1'b0;
                    fcnt_d  = '0;
                    state_d = IDLE;
                end else begin
                    fcnt_d = fcnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            fcnt_q     <= '0;
            ctrl_q     <= '0;
            a_q        <= '0;
            b_q        <= '0;
            pc_q       <= '0;
            imm_q      <= '0;
            pred_q     <= 1'b0;
            resolved_q <= 1'b0;
            taken_q    <= 1'b0;
            mis_q      <= 1'b0;
            ill_q      <= 1'b0;
            rv_q       <= 1'b0;
            rpc_q      <= '0;
            flush_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fcnt_q     <= fcnt_d;
            resolved_q <= resolved_d;
            taken_q    <= taken_d;
            mis_q      <= mis_d;
            ill_q      <= ill_d;
            rv_q       <= rv_d;
            rpc_q      <= rpc_d;
            flush_q    <= flush_d;
            if (accept) begin
                ctrl_q <= bus.Br_Ctrl;
                a_q    <= bus.SrcA;
                b_q    <= bus.SrcB;
                pc_q   <= bus.pc;
                imm_q  <= bus.imm;
                pred_q <= bus.pred_taken;
            end
        end
    end

    assign bus.in_ready       = (state_q == IDLE);
    assign bus.redirect_valid = rv_q;
    assign bus.redirect_pc    = rpc_q;
    assign resolved_valid     = resolved_q;
    assign taken              = taken_q;
    assign mispredict         = mis_q;
    assign illegal            = ill_q;
    assign flush              = flush_q;

`ifdef BRANCH_RESOLVE_PERF_EN
    logic [31:0] br_q, mp_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            br_q <= '0;
            mp_q <= '0;
        end else begin
            if (resolved_q && (br_q != 32'hFFFF_FFFF)) br_q <= br_q + 32'd1;
            if (resolved_q && mis_q && (mp_q != 32'hFFFF_FFFF)) mp_q <= mp_q + 32'd1;
        end
    end

    assign br_count      = br_q;
    assign mispred_count = mp_q;
`else
    assign br_count      = 32'd0;
    assign mispred_count = 32'd0;
`endif
endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// tb/tb_branch_resolve_ctrl.sv - directed self-checking bench for branch_resolve_ctrl
module tb_branch_resolve_ctrl;
    logic        clk;
    logic        rst;
    logic        kill;
    logic        resolved_valid, taken, mispredict, illegal, flush;
    logic [31:0] br_count, mispred_count;
    int          total;
    int          bad;

    branch_resolve_ctrl_if #(.XLEN(32)) bus ();

    branch_resolve_ctrl #(.XLEN(32), .FLUSH_CYCLES(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .kill           (kill),
        .resolved_valid (resolved_valid),
        .taken          (taken),
        .mispredict     (mispredict),
        .illegal        (illegal),
        .flush          (flush),
        .br_count       (br_count),
        .mispred_count  (mispred_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one branch from IDLE; returns one step after E1 with results visible.
    task automatic issue(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] p, input logic [31:0] i, input logic pr);
        bus.Br_Ctrl    = c;
        bus.SrcA       = a;
        bus.SrcB       = b;
        bus.pc         = p;
        bus.imm        = i;
        bus.pred_taken = pr;
        bus.in_valid   = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk("eval_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("eval_resolved", {31'd0, resolved_valid}, 32'd0);
        step();
    endtask

    task automatic finish_redirect();
        bus.redirect_ready = 1'b1;
        step();
        bus.redirect_ready = 1'b0;
        chk("hs_rv_drop", {31'd0, bus.redirect_valid}, 32'd0);
        chk("hs_flush1", {31'd0, flush}, 32'd1);
        step();
        chk("hs_flush2", {31'd0, flush}, 32'd1);
        step();
        chk("hs_flush_end", {31'd0, flush}, 32'd0);
        chk("hs_idle", {31'd0, bus.in_ready}, 32'd1);
    endtask

    logic [2:0]  t_ctrl [10];
    logic [31:0] t_a    [10];
    logic [31:0] t_b    [10];
    logic        t_pred [10];
    logic        t_tk   [10];
    logic [31:0] exp_br, exp_mp;
    int          nmis;

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        kill  = 1'b0;
        bus.in_valid       = 1'b0;
        bus.Br_Ctrl        = 3'b000;
        bus.SrcA           = '0;
        bus.SrcB           = '0;
        bus.pc             = '0;
        bus.imm            = '0;
        bus.pred_taken     = 1'b0;
        bus.redirect_ready = 1'b0;
        step();
        step();
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_resolved", {31'd0, resolved_valid}, 32'd0);
        chk("rst_rv", {31'd0, bus.redirect_valid}, 32'd0);
        chk("rst_rpc", bus.redirect_pc, 32'd0);
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_brc", br_count, 32'd0);
        chk("rst_mpc", mispred_count, 32'd0);
        rst = 1'b0;
        step();

        // EQ taken, correctly predicted
        issue(3'b000, 32'h5, 32'h5, 32'h100, 32'h20, 1'b1);
        chk("t1_resolved", {31'd0, resolved_valid}, 32'd1);
        chk("t1_taken", {31'd0, taken}, 32'd1);
        chk("t1_mis", {31'd0, mispredict}, 32'd0);
        chk("t1_rv", {31'd0, bus.redirect_valid}, 32'd0);
        chk("t1_rpc", bus.redirect_pc, 32'h120);
        chk("t1_in_ready", {31'd0, bus.in_ready}, 32'd1);
        step();
        chk("t1_pulse_end", {31'd0, resolved_valid}, 32'd0);

        // signed LT taken, predicted not-taken; fetch stalls the redirect
        issue(3'b100, 32'hFFFF_FFFF, 32'h1, 32'h200, 32'h40, 1'b0);
        chk("t2_taken", {31'd0, taken}, 32'd1);
        chk("t2_mis", {31'd0, mispredict}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            chk("t2_rv_hold", {31'd0, bus.redirect_valid}, 32'd1);
            chk("t2_rpc_hold", bus.redirect_pc, 32'h240);
            chk("t2_no_flush", {31'd0, flush}, 32'd0);
            if (k < 2) step();
        end
        finish_redirect();

        // unsigned LT not-taken, predicted taken
        issue(3'b110, 32'hFFFF_FFFF, 32'h1, 32'h300, 32'h40, 1'b1);
        chk("t3_taken", {31'd0, taken}, 32'd0);
        chk("t3_mis", {31'd0, mispredict}, 32'd1);
        chk("t3_rpc", bus.redirect_pc, 32'h304);
        chk("t3_rv", {31'd0, bus.redirect_valid}, 32'd1);
        finish_redirect();

        // illegal encoding
        issue(3'b010, 32'h1, 32'h1, 32'h400, 32'h10, 1'b0);
        chk("t4_illegal", {31'd0, illegal}, 32'd1);
        chk("t4_taken", {31'd0, taken}, 32'd0);
        chk("t4_rv", {31'd0, bus.redirect_valid}, 32'd0);

        // GEU equal operands, target wraps past 2^32
        issue(3'b111, 32'h7, 32'h7, 32'hFFFF_FFF0, 32'h20, 1'b1);
        chk("t5_taken", {31'd0, taken}, 32'd1);
        chk("t5_illegal", {31'd0, illegal}, 32'd0);
        chk("t5_rpc_wrap", bus.redirect_pc, 32'h10);

        // kill during EVAL suppresses a would-be mispredict
        bus.Br_Ctrl    = 3'b000;
        bus.SrcA       = 32'h1;
        bus.SrcB       = 32'h1;
        bus.pc         = 32'h500;
        bus.imm        = 32'h8;
        bus.pred_taken = 1'b0;
        bus.in_valid   = 1'b1;
        step();
        bus.in_valid = 1'b0;
        kill = 1'b1;
        step();
        kill = 1'b0;
        chk("t6_no_resolved", {31'd0, resolved_valid}, 32'd0);
        chk("t6_no_rv", {31'd0, bus.redirect_valid}, 32'd0);
        chk("t6_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // kill wins over redirect_ready in REDIRECT
        issue(3'b001, 32'h1, 32'h2, 32'h600, 32'h10, 1'b0);
        chk("t7_rv", {31'd0, bus.redirect_valid}, 32'd1);
        kill = 1'b1;
        bus.redirect_ready = 1'b1;
        step();
        kill = 1'b0;
        bus.redirect_ready = 1'b0;
        chk("t7_rv_drop", {31'd0, bus.redirect_valid}, 32'd0);
        chk("t7_no_flush", {31'd0, flush}, 32'd0);
        chk("t7_in_ready", {31'd0, bus.in_ready}, 32'd1);
        step();
        chk("t7_still_no_flush", {31'd0, flush}, 32'd0);

        // reset pulse while flushing
        issue(3'b001, 32'h1, 32'h2, 32'h700, 32'h10, 1'b0);
        bus.redirect_ready = 1'b1;
        step();
        bus.redirect_ready = 1'b0;
        chk("t8_flush", {31'd0, flush}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t8_rst_flush", {31'd0, flush}, 32'd0);
        chk("t8_rst_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("t8_rst_rv", {31'd0, bus.redirect_valid}, 32'd0);
        chk("t8_rst_brc", br_count, 32'd0);

        // ten branches, three mispredicts (entries 3, 5, 7)
        t_ctrl[0] = 3'b001; t_a[0] = 32'h5;         t_b[0] = 32'h6;         t_pred[0] = 1'b1; t_tk[0] = 1'b1;
        t_ctrl[1] = 3'b001; t_a[1] = 32'h5;         t_b[1] = 32'h5;         t_pred[1] = 1'b0; t_tk[1] = 1'b0;
        t_ctrl[2] = 3'b101; t_a[2] = 32'h8000_0000; t_b[2] = 32'h1;         t_pred[2] = 1'b0; t_tk[2] = 1'b0;
        t_ctrl[3] = 3'b101; t_a[3] = 32'h3;         t_b[3] = 32'h3;         t_pred[3] = 1'b0; t_tk[3] = 1'b1;
        t_ctrl[4] = 3'b100; t_a[4] = 32'h2;         t_b[4] = 32'hFFFF_FFFE; t_pred[4] = 1'b0; t_tk[4] = 1'b0;
        t_ctrl[5] = 3'b110; t_a[5] = 32'h1;         t_b[5] = 32'hFFFF_FFFF; t_pred[5] = 1'b0; t_tk[5] = 1'b1;
        t_ctrl[6] = 3'b111; t_a[6] = 32'h0;         t_b[6] = 32'h1;         t_pred[6] = 1'b0; t_tk[6] = 1'b0;
        t_ctrl[7] = 3'b000; t_a[7] = 32'h9;         t_b[7] = 32'h8;         t_pred[7] = 1'b1; t_tk[7] = 1'b0;
        t_ctrl[8] = 3'b011; t_a[8] = 32'h4;         t_b[8] = 32'h4;         t_pred[8] = 1'b0; t_tk[8] = 1'b0;
        t_ctrl[9] = 3'b000; t_a[9] = 32'h0;         t_b[9] = 32'h0;         t_pred[9] = 1'b1; t_tk[9] = 1'b1;
        nmis = 0;
        for (int n = 0; n < 10; n++) begin
            issue(t_ctrl[n], t_a[n], t_b[n], 32'h1000 + 32'(n * 8), 32'h100, t_pred[n]);
            chk("p_resolved", {31'd0, resolved_valid}, 32'd1);
            chk("p_taken", {31'd0, taken}, {31'd0, t_tk[n]});
            chk("p_mis", {31'd0, mispredict}, {31'd0, t_tk[n] != t_pred[n]});
            chk("p_rpc", bus.redirect_pc,
                t_tk[n] ? (32'h1100 + 32'(n * 8)) : (32'h1004 + 32'(n * 8)));
            if (t_tk[n] != t_pred[n]) begin
                nmis++;
                finish_redirect();
            end
        end
        step();
        step();
`ifdef BRANCH_RESOLVE_PERF_EN
        exp_br = 32'd10;
        exp_mp = 32'd3;
`else
        exp_br = 32'd0;
        exp_mp = 32'd0;
`endif
        chk("perf_nmis", 32'(nmis), 32'd3);
        chk("perf_br_count", br_count, exp_br);
        chk("perf_mispred_count", mispred_count, exp_mp);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
